// File: rtl/ysyx_22040632_axi_sram_if.sv
// AXI4 bus bundle between a master and the SRAM slave.
// Handshake rule: a beat transfers on a posedge where valid && ready; valid must not wait for ready, and payload stays stable while valid && !ready.
interface ysyx_22040632_axi_sram_if #(
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_ID_WIDTH   = 4
);
  logic                        axi_aw_valid_i;
  logic                        axi_aw_ready_o;
  logic [AXI_ADDR_WIDTH-1:0]   axi_aw_addr_i;
  logic [AXI_ID_WIDTH-1:0]     axi_aw_id_i;
  logic [7:0]                  axi_aw_len_i;
  logic                        axi_w_valid_i;
  logic                        axi_w_ready_o;
  logic [AXI_DATA_WIDTH-1:0]   axi_w_data_i;
  logic [AXI_DATA_WIDTH/8-1:0] axi_w_strb_i;
  logic                        axi_w_last_i;
  logic                        axi_b_valid_o;
  logic                        axi_b_ready_i;
  logic [1:0]                  axi_b_resp_o;
  logic [AXI_ID_WIDTH-1:0]     axi_b_id_o;
  logic                        axi_ar_valid_i;
  logic                        axi_ar_ready_o;
  logic [AXI_ADDR_WIDTH-1:0]   axi_ar_addr_i;
  logic [AXI_ID_WIDTH-1:0]     axi_ar_id_i;
  logic [7:0]                  axi_ar_len_i;
  logic                        axi_r_valid_o;
  logic                        axi_r_ready_i;
  logic [AXI_DATA_WIDTH-1:0]   axi_r_data_o;
  logic [1:0]                  axi_r_resp_o;
  logic                        axi_r_last_o;
  logic [AXI_ID_WIDTH-1:0]     axi_r_id_o;

  modport master (
    output axi_aw_valid_i, axi_aw_addr_i, axi_aw_id_i, axi_aw_len_i,
    output axi_w_valid_i, axi_w_data_i, axi_w_strb_i, axi_w_last_i, axi_b_ready_i,
    output axi_ar_valid_i, axi_ar_addr_i, axi_ar_id_i, axi_ar_len_i, axi_r_ready_i,
    input  axi_aw_ready_o, axi_w_ready_o, axi_b_valid_o, axi_b_resp_o, axi_b_id_o,
    input  axi_ar_ready_o, axi_r_valid_o, axi_r_data_o, axi_r_resp_o, axi_r_last_o, axi_r_id_o
  );

  modport slave (
    input  axi_aw_valid_i, axi_aw_addr_i, axi_aw_id_i, axi_aw_len_i,
    input  axi_w_valid_i, axi_w_data_i, axi_w_strb_i, axi_w_last_i, axi_b_ready_i,
    input  axi_ar_valid_i, axi_ar_addr_i, axi_ar_id_i, axi_ar_len_i, axi_r_ready_i,
    output axi_aw_ready_o, axi_w_ready_o, axi_b_valid_o, axi_b_resp_o, axi_b_id_o,
    output axi_ar_ready_o, axi_r_valid_o, axi_r_data_o, axi_r_resp_o, axi_r_last_o, axi_r_id_o
  );
endinterface

// File: rtl/ysyx_22040632_axi_sram.sv
// AXI4 SRAM slave: MEM_WORDS x 64-bit words at 0x8000_0000 with independent INCR read and write burst engines.
// Define YSYX_22040632_AXI_SRAM_LAT_EN to add 4 cycles before the first R beat and before B.
module ysyx_22040632_axi_sram #(
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int MEM_WORDS      = 4096
) (
  input  logic                    clk,
  input  logic                    rst_n,
  ysyx_22040632_axi_sram_if.slave bus,
  output logic [1:0]              r_state_dbg,
  output logic [1:0]              w_state_dbg,
  output logic                    w_len_mismatch_dbg
);
  localparam int IDX_W  = $clog2(MEM_WORDS);
  localparam int STRB_W = AXI_DATA_WIDTH / 8;
  localparam logic [AXI_ADDR_WIDTH-1:0] BASE = AXI_ADDR_WIDTH'(32'h8000_0000);
`ifdef YSYX_22040632_AXI_SRAM_LAT_EN
  localparam logic [2:0] LAT = 3'd4;
`else
  localparam logic [2:0] LAT = 3'd0;
`endif
  localparam logic [2:0] LAT_LAST = LAT - 3'd1;

  typedef enum logic [1:0] {R_IDLE = 2'd0, R_WAIT = 2'd1, R_DATA = 2'd2} r_state_t;
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_t;

  logic [AXI_DATA_WIDTH-1:0] mem [MEM_WORDS];

  function automatic logic in_range(input logic [AXI_ADDR_WIDTH-1:0] a);
    logic [AXI_ADDR_WIDTH-1:0] off;
    off = a - BASE;
    return (a >= BASE) && ((off >> 3) < AXI_ADDR_WIDTH'(MEM_WORDS));
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [AXI_ADDR_WIDTH-1:0] a);
    logic [AXI_ADDR_WIDTH-1:0] off;
    off = a - BASE;
    return off[IDX_W+2:3];
  endfunction

  // Holds both address-ready outputs low while reset is asserted and for the release edge.
  logic out_en;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_en <= 1'b0;
    else        out_en <= 1'b1;
  end

  // ---------------- read engine ----------------
  r_state_t                  r_state, r_next;
  logic [AXI_ADDR_WIDTH-1:0] r_addr, r_load_addr;
  logic [7:0]                r_len, r_beat;
  logic [2:0]                r_wait_cnt;
  logic [AXI_DATA_WIDTH-1:0] r_data;
  logic [AXI_ID_WIDTH-1:0]   r_id;
  logic                      r_err, r_load, r_last, ar_ready, r_valid, ar_fire;

  assign r_last  = (r_state == R_DATA) && (r_beat == r_len);
  assign ar_fire = ar_ready && bus.axi_ar_valid_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= R_IDLE;
    else        r_state <= r_next;
  end

  always_comb begin
    r_next      = r_state;
    r_load      = 1'b0;
    r_load_addr = r_addr;
    ar_ready    = 1'b0;
    r_valid     = 1'b0;
    case (r_state)
      R_IDLE: begin
        ar_ready    = out_en;
        r_load_addr = bus.axi_ar_addr_i;
        if (out_en && bus.axi_ar_valid_i) begin
          r_next = (LAT == 3'd0) ? R_DATA : R_WAIT;
          r_load = (LAT == 3'd0);
        end
      end
      R_WAIT: begin
        if (r_wait_cnt == LAT_LAST) begin
          r_next = R_DATA;
          r_load = 1'b1;
        end
      end
      R_DATA: begin
        r_valid     = 1'b1;
        r_load_addr = r_addr + AXI_ADDR_WIDTH'(8);
        if (bus.axi_r_ready_i) begin
          if (r_last) r_next = R_IDLE;
          else        r_load = 1'b1;
        end
      end
      default: r_next = R_IDLE;
    endcase
  end

  // Beat data is captured into a register so it stays stable under stalls and sees pre-write contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr     <= '0;
      r_len      <= '0;
      r_beat     <= '0;
      r_id       <= '0;
      r_wait_cnt <= '0;
      r_err      <= 1'b0;
      r_data     <= '0;
    end else begin
      r_wait_cnt <= (r_state == R_WAIT) ? r_wait_cnt + 3'd1 : 3'd0;
      if (ar_fire) begin
        r_addr <= bus.axi_ar_addr_i;
        r_len  <= bus.axi_ar_len_i;
        r_id   <= bus.axi_ar_id_i;
        r_beat <= '0;
      end else if (r_valid && bus.axi_r_ready_i && !r_last) begin
        r_addr <= r_load_addr;
        r_beat <= r_beat + 8'd1;
      end
      if (r_load) begin
        r_err  <= !in_range(r_load_addr);
        r_data <= in_range(r_load_addr) ? mem[word_idx(r_load_addr)] : '0;
      end
    end
  end

  assign bus.axi_ar_ready_o = ar_ready;
  assign bus.axi_r_valid_o  = r_valid;
  assign bus.axi_r_data_o   = r_data;
  assign bus.axi_r_resp_o   = r_err ? 2'b10 : 2'b00;
  assign bus.axi_r_last_o   = r_last;
  assign bus.axi_r_id_o     = r_id;
  assign r_state_dbg        = r_state;

  // ---------------- write engine ----------------
  w_state_t                  w_state, w_next;
  logic [AXI_ADDR_WIDTH-1:0] w_addr;
  logic [AXI_ID_WIDTH-1:0]   b_id;
  logic [7:0]                w_len;
  logic [8:0]                w_beat;
  logic [2:0]                w_lat_cnt;
  logic                      w_err, aw_ready, w_ready, b_valid, w_fire;

  assign w_fire = w_ready && bus.axi_w_valid_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) w_state <= W_IDLE;
    else        w_state <= w_next;
  end

  always_comb begin
    w_next   = w_state;
    aw_ready = 1'b0;
    w_ready  = 1'b0;
    b_valid  = 1'b0;
    case (w_state)
      W_IDLE: begin
        aw_ready = out_en;
        if (out_en && bus.axi_aw_valid_i) w_next = W_DATA;
      end
      W_DATA: begin
        w_ready = 1'b1;
        if (bus.axi_w_valid_i && bus.axi_w_last_i) w_next = W_RESP;
      end
      W_RESP: begin
        b_valid = (w_lat_cnt == LAT);
        if (b_valid && bus.axi_b_ready_i) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_addr    <= '0;
      b_id      <= '0;
      w_len     <= '0;
      w_beat    <= '0;
      w_lat_cnt <= '0;
      w_err     <= 1'b0;
    end else begin
      if (w_state != W_RESP)  w_lat_cnt <= 3'd0;
      else if (w_lat_cnt != LAT) w_lat_cnt <= w_lat_cnt + 3'd1;
      if (aw_ready && bus.axi_aw_valid_i) begin
        w_addr <= bus.axi_aw_addr_i;
        b_id   <= bus.axi_aw_id_i;
        w_len  <= bus.axi_aw_len_i;
        w_beat <= '0;
        w_err  <= 1'b0;
      end else if (w_fire) begin
        w_addr <= w_addr + AXI_ADDR_WIDTH'(8);
        w_beat <= w_beat + 9'd1;
        if (!in_range(w_addr)) w_err <= 1'b1;
      end
    end
  end

  // Memory is deliberately not reset so contents survive rst_n.
  always_ff @(posedge clk) begin
    if (w_fire && in_range(w_addr)) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (bus.axi_w_strb_i[b]) mem[word_idx(w_addr)][b*8 +: 8] <= bus.axi_w_data_i[b*8 +: 8];
      end
    end
  end

  assign bus.axi_aw_ready_o = aw_ready;
  assign bus.axi_w_ready_o  = w_ready;
  assign bus.axi_b_valid_o  = b_valid;
  assign bus.axi_b_resp_o   = w_err ? 2'b10 : 2'b00;
  assign bus.axi_b_id_o     = b_id;
  assign w_state_dbg        = w_state;
  assign w_len_mismatch_dbg = (w_state == W_RESP) && (w_beat != ({1'b0, w_len} + 9'd1));
endmodule

// File: tb/tb_ysyx_22040632_axi_sram.sv
// Bench for ysyx_22040632_axi_sram: directed vector table, burst/stall/reset sequences, random traffic vs a word-array model.
`timescale 1ns/1ps
module tb_ysyx_22040632_axi_sram;
  localparam logic [31:0] BASE = 32'h8000_0000;
`ifdef YSYX_22040632_AXI_SRAM_LAT_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] r_state_dbg, w_state_dbg;
  logic       w_len_mismatch_dbg;

  ysyx_22040632_axi_sram_if bus ();

  ysyx_22040632_axi_sram dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .bus                (bus),
    .r_state_dbg        (r_state_dbg),
    .w_state_dbg        (w_state_dbg),
    .w_len_mismatch_dbg (w_len_mismatch_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] exp_q[$];
  logic [1:0]  exp_resp_q[$];
  bit          exp_known_q[$];
  logic [63:0] wdata_q[$];
  logic [7:0]  wstrb_q[$];
  logic [63:0] model [int];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit ref_in_range(input logic [31:0] a);
    longint unsigned x, b;
    x = {32'd0, a};
    b = {32'd0, BASE};
    return (x >= b) && (x < b + 64'd32768);
  endfunction

  function automatic int ref_index(input logic [31:0] a);
    longint unsigned x;
    x = {32'd0, a} - {32'd0, BASE};
    return int'(x / 8);
  endfunction

  task automatic push_expected(input logic [31:0] addr, input int len);
    logic [31:0] ba;
    for (int i = 0; i <= len; i++) begin
      ba = addr + 32'(8 * i);
      if (ref_in_range(ba) && model.exists(ref_index(ba))) begin
        exp_q.push_back(model[ref_index(ba)]); exp_known_q.push_back(1'b1); exp_resp_q.push_back(2'b00);
      end else if (ref_in_range(ba)) begin
        exp_q.push_back(64'd0); exp_known_q.push_back(1'b0); exp_resp_q.push_back(2'b00);
      end else begin
        exp_q.push_back(64'd0); exp_known_q.push_back(1'b1); exp_resp_q.push_back(2'b10);
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  // mode 0: r_ready always high, 1: toggles 1,0,1,0..., 2: random
  task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id, input int mode);
    int budget, k, beat, cyc;
    bit rdy;
    @(negedge clk);
    bus.axi_ar_valid_i = 1'b1; bus.axi_ar_addr_i = addr; bus.axi_ar_len_i = len; bus.axi_ar_id_i = id;
    budget = 0;
    while (!bus.axi_ar_ready_o && budget < 100) begin @(negedge clk); budget++; end
    if (!bus.axi_ar_ready_o) begin
      check("ar_ready_timeout", 0, 1);
      bus.axi_ar_valid_i = 1'b0; exp_q.delete(); exp_resp_q.delete(); exp_known_q.delete();
      return;
    end
    @(negedge clk);
    bus.axi_ar_valid_i = 1'b0;
    k = 1;
    while (!bus.axi_r_valid_o && k < 100) begin @(negedge clk); k++; end
    check("r_first_latency", k, 1 + LAT);
    check("ar_ready_busy", bus.axi_ar_ready_o, 0);
    beat = 0; cyc = 0; budget = 0;
    while (beat <= int'(len) && budget < 2000) begin
      if (bus.axi_r_valid_o && exp_q.size() > 0) begin
        case (mode)
          0:       rdy = 1'b1;
          1:       rdy = (cyc % 2 == 0);
          default: rdy = 1'($urandom_range(0, 1));
        endcase
        cyc++;
        bus.axi_r_ready_i = rdy;
        if (exp_known_q[0]) check("r_data", bus.axi_r_data_o, exp_q[0]);
        check("r_resp", bus.axi_r_resp_o, exp_resp_q[0]);
        check("r_last", bus.axi_r_last_o, (beat == int'(len)));
        check("r_id", bus.axi_r_id_o, id);
        if (rdy) begin
          void'(exp_q.pop_front()); void'(exp_resp_q.pop_front()); void'(exp_known_q.pop_front());
          beat++;
        end
      end else begin
        bus.axi_r_ready_i = 1'b0;
      end
      @(negedge clk);
      budget++;
    end
    bus.axi_r_ready_i = 1'b0;
    if (beat <= int'(len)) check("r_beats_timeout", beat, len + 1);
    check("r_valid_after_last", bus.axi_r_valid_o, 0);
    check("ar_ready_after_last", bus.axi_ar_ready_o, 1);
    exp_q.delete(); exp_resp_q.delete(); exp_known_q.delete();
  endtask

  // Sends nbeats beats from wdata_q/wstrb_q; w_last on the final one regardless of len.
  task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id,
                          input int nbeats, input int mode, output logic [1:0] bresp);
    int budget, k;
    bit err;
    logic [31:0] ba;
    int idx;
    bresp = 2'bxx;
    @(negedge clk);
    bus.axi_aw_valid_i = 1'b1; bus.axi_aw_addr_i = addr; bus.axi_aw_len_i = len; bus.axi_aw_id_i = id;
    budget = 0;
    while (!bus.axi_aw_ready_o && budget < 100) begin @(negedge clk); budget++; end
    if (!bus.axi_aw_ready_o) begin
      check("aw_ready_timeout", 0, 1);
      bus.axi_aw_valid_i = 1'b0; wdata_q.delete(); wstrb_q.delete();
      return;
    end
    @(negedge clk);
    bus.axi_aw_valid_i = 1'b0;
    check("aw_ready_busy", bus.axi_aw_ready_o, 0);
    err = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      if (mode != 0) begin
        bus.axi_w_valid_i = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      bus.axi_w_valid_i = 1'b1; bus.axi_w_data_i = wdata_q[i]; bus.axi_w_strb_i = wstrb_q[i];
      bus.axi_w_last_i = (i == nbeats - 1);
      budget = 0;
      while (!bus.axi_w_ready_o && budget < 100) begin @(negedge clk); budget++; end
      if (!bus.axi_w_ready_o) begin
        check("w_ready_timeout", 0, 1);
        break;
      end
      ba = addr + 32'(8 * i);
      if (!ref_in_range(ba)) err = 1'b1;
      else begin
        idx = ref_index(ba);
        if (wstrb_q[i] == 8'hFF) model[idx] = wdata_q[i];
        else if (model.exists(idx))
          for (int b = 0; b < 8; b++) if (wstrb_q[i][b]) model[idx][b*8 +: 8] = wdata_q[i][b*8 +: 8];
      end
      @(negedge clk);
    end
    bus.axi_w_valid_i = 1'b0; bus.axi_w_last_i = 1'b0;
    wdata_q.delete(); wstrb_q.delete();
    k = 1;
    while (!bus.axi_b_valid_o && k < 100) begin @(negedge clk); k++; end
    check("b_latency", k, 1 + LAT);
    repeat ($urandom_range(0, 2)) begin
      @(negedge clk);
      check("b_valid_held", bus.axi_b_valid_o, 1);
    end
    bresp = bus.axi_b_resp_o;
    check("b_resp", bus.axi_b_resp_o, err ? 2'b10 : 2'b00);
    check("b_id", bus.axi_b_id_o, id);
    check("w_len_mismatch", w_len_mismatch_dbg, (nbeats != int'(len) + 1));
    bus.axi_b_ready_i = 1'b1;
    @(negedge clk);
    bus.axi_b_ready_i = 1'b0;
    check("b_valid_after_ack", bus.axi_b_valid_o, 0);
    check("aw_ready_after_ack", bus.axi_aw_ready_o, 1);
  endtask

  // ---------------- test ----------------
  typedef struct {
    bit          do_write;
    logic [31:0] addr;
    logic [63:0] wdata;
    logic [7:0]  strb;
    logic [1:0]  exp_bresp;
    logic [63:0] exp_rdata;
    logic [1:0]  exp_rresp;
  } vec_t;

  vec_t        vecs[10];
  logic [1:0]  bresp;
  logic [31:0] addr;
  logic [7:0]  len;

  initial begin
    vecs[0] = '{1'b1, 32'h8000_0000, 64'h1122334455667788, 8'hFF, 2'b00, 64'h1122334455667788, 2'b00};
    vecs[1] = '{1'b1, 32'h8000_0000, 64'hAAAAAAAABBBBBBBB, 8'h0F, 2'b00, 64'h11223344BBBBBBBB, 2'b00};
    vecs[2] = '{1'b1, 32'h8000_8000, 64'hCAFEF00DCAFEF00D, 8'hFF, 2'b10, 64'h0, 2'b10};
    vecs[3] = '{1'b0, 32'h8000_0000, 64'h0, 8'h00, 2'b00, 64'h11223344BBBBBBBB, 2'b00};
    vecs[4] = '{1'b1, 32'h7FFF_FFF8, 64'h0123456789ABCDEF, 8'hFF, 2'b10, 64'h0, 2'b10};
    vecs[5] = '{1'b1, 32'h8000_7FF8, 64'hDEADBEEF01234567, 8'hFF, 2'b00, 64'hDEADBEEF01234567, 2'b00};
    vecs[6] = '{1'b1, 32'h8000_0008, 64'h0123456789ABCDEF, 8'hFF, 2'b00, 64'h0123456789ABCDEF, 2'b00};
    vecs[7] = '{1'b1, 32'h8000_0008, 64'hFFFFFFFFFFFFFFFF, 8'h81, 2'b00, 64'hFF23456789ABCDFF, 2'b00};
    vecs[8] = '{1'b1, 32'h8000_000D, 64'h5555555555555555, 8'h00, 2'b00, 64'hFF23456789ABCDFF, 2'b00};
    vecs[9] = '{1'b0, 32'h8000_0003, 64'h0, 8'h00, 2'b00, 64'h11223344BBBBBBBB, 2'b00};

    bus.axi_aw_valid_i = 0; bus.axi_aw_addr_i = 0; bus.axi_aw_id_i = 0; bus.axi_aw_len_i = 0;
    bus.axi_w_valid_i = 0; bus.axi_w_data_i = 0; bus.axi_w_strb_i = 0; bus.axi_w_last_i = 0;
    bus.axi_b_ready_i = 0;
    bus.axi_ar_valid_i = 0; bus.axi_ar_addr_i = 0; bus.axi_ar_id_i = 0; bus.axi_ar_len_i = 0;
    bus.axi_r_ready_i = 0;

    // reset state
    #12;
    check("rst_ar_ready", bus.axi_ar_ready_o, 0);
    check("rst_aw_ready", bus.axi_aw_ready_o, 0);
    check("rst_r_valid", bus.axi_r_valid_o, 0);
    check("rst_w_ready", bus.axi_w_ready_o, 0);
    check("rst_b_valid", bus.axi_b_valid_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("ar_ready_before_edge", bus.axi_ar_ready_o, 0);
    @(negedge clk);
    check("ar_ready_after_release", bus.axi_ar_ready_o, 1);
    check("aw_ready_after_release", bus.axi_aw_ready_o, 1);

    // directed vectors: single-beat write then single-beat read
    for (int v = 0; v < 10; v++) begin
      if (vecs[v].do_write) begin
        wdata_q.push_back(vecs[v].wdata); wstrb_q.push_back(vecs[v].strb);
        do_write(vecs[v].addr, 8'd0, 4'(v), 1, 0, bresp);
        check("vec_bresp", bresp, vecs[v].exp_bresp);
      end
      exp_q.push_back(vecs[v].exp_rdata); exp_resp_q.push_back(vecs[v].exp_rresp); exp_known_q.push_back(1'b1);
      do_read(vecs[v].addr, 8'd0, 4'(v + 1), 0);
    end

    // preload words 0..63 and 4088..4095
    for (int i = 0; i < 64; i++) begin wdata_q.push_back({$urandom, $urandom}); wstrb_q.push_back(8'hFF); end
    do_write(BASE, 8'd63, 4'd3, 64, 0, bresp);
    for (int i = 0; i < 8; i++) begin wdata_q.push_back({$urandom, $urandom}); wstrb_q.push_back(8'hFF); end
    do_write(BASE + 32'(8 * 4088), 8'd7, 4'd4, 8, 1, bresp);

    // 4-beat read of words 2..5 with r_ready toggling
    push_expected(32'h8000_0010, 3);
    do_read(32'h8000_0010, 8'd3, 4'd9, 1);

    // reset in the middle of an 8-beat read
    @(negedge clk);
    bus.axi_ar_valid_i = 1'b1; bus.axi_ar_addr_i = BASE; bus.axi_ar_len_i = 8'd7; bus.axi_ar_id_i = 4'd5;
    check("mid_ar_ready", bus.axi_ar_ready_o, 1);
    @(negedge clk);
    bus.axi_ar_valid_i = 1'b0; bus.axi_r_ready_i = 1'b1;
    check("mid_beat0", bus.axi_r_data_o, model[0]);
    @(negedge clk);
    check("mid_beat1", bus.axi_r_data_o, model[1]);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_r_valid", bus.axi_r_valid_o, 0);
    check("mid_rst_ar_ready", bus.axi_ar_ready_o, 0);
    check("mid_rst_aw_ready", bus.axi_aw_ready_o, 0);
    check("mid_rst_r_last", bus.axi_r_last_o, 0);
    bus.axi_r_ready_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("mid_ar_ready_pre_edge", bus.axi_ar_ready_o, 0);
    @(negedge clk);
    check("mid_ar_ready_release", bus.axi_ar_ready_o, 1);
    push_expected(BASE + 32'h20, 2);
    do_read(BASE + 32'h20, 8'd2, 4'd6, 0);

    // write burst ended early by w_last, then read it back
    for (int i = 0; i < 2; i++) begin wdata_q.push_back({$urandom, $urandom}); wstrb_q.push_back(8'hFF); end
    do_write(BASE + 32'h100, 8'd3, 4'd7, 2, 0, bresp);
    push_expected(BASE + 32'h100, 1);
    do_read(BASE + 32'h100, 8'd1, 4'd8, 0);

    // random traffic against the model
    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(0, 2))
        0:       addr = BASE + 32'(8 * $urandom_range(0, 56)) + 32'($urandom_range(0, 7));
        1:       addr = BASE + 32'(8 * (4090 + $urandom_range(0, 8))) + 32'($urandom_range(0, 7));
        default: addr = 32'h7FFF_FFE0 + 32'(8 * $urandom_range(0, 3)) + 32'($urandom_range(0, 7));
      endcase
      len = 8'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i <= int'(len); i++) begin
          wdata_q.push_back({$urandom, $urandom});
          wstrb_q.push_back(($urandom_range(0, 1) == 1) ? 8'hFF : 8'($urandom));
        end
        do_write(addr, len, 4'($urandom), int'(len) + 1, 1, bresp);
      end else begin
        push_expected(addr, int'(len));
        do_read(addr, len, 4'($urandom), 2);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
